// File: rtl/iomem_fabric.sv
// iomem_fabric
//   PicoSoC iomem interconnect. Decodes the slot field of iomem_addr
//   against NUM_SLAVES slot IDs, forwards the request to one slave, and
//   returns that slave's registered response to the core. Unmapped
//   addresses and slaves that stay silent for TIMEOUT_CYCLES cycles are
//   completed with a zero read value and a one-cycle err_irq, so a
//   missing peripheral can never hang the core.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   iomem_valid/ready/wstrb/addr/wdata/rdata
//                                   core-side request / response
//   s_valid [N]                     per-slot request (one-hot or zero)
//   s_ready [N], s_rdata [32*N]     per-slot completion and read data
//   s_wstrb/s_addr/s_wdata          combinational pass-through of the request
//   err_irq                         one-cycle pulse on decode miss or timeout
//   err_addr, err_timeout           address / kind of the most recent error
module iomem_fabric #(
  parameter int                    NUM_SLAVES     = 4,
  parameter int                    SEL_MSB        = 31,
  parameter int                    SEL_LSB        = 24,
  parameter logic [8*NUM_SLAVES-1:0] SLOT_IDS     = {8'h07, 8'h05, 8'h04, 8'h03},
  parameter logic [NUM_SLAVES-1:0] ALWAYS_READY   = 4'b0110,
  parameter int                    TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    iomem_valid,
  output logic                    iomem_ready,
  input  logic [3:0]              iomem_wstrb,
  input  logic [31:0]             iomem_addr,
  input  logic [31:0]             iomem_wdata,
  output logic [31:0]             iomem_rdata,
  output logic [NUM_SLAVES-1:0]   s_valid,
  input  logic [NUM_SLAVES-1:0]   s_ready,
  input  logic [32*NUM_SLAVES-1:0] s_rdata,
  output logic [3:0]              s_wstrb,
  output logic [31:0]             s_addr,
  output logic [31:0]             s_wdata,
  output logic                    err_irq,
  output logic [31:0]             err_addr,
  output logic                    err_timeout
);

  localparam int FW    = SEL_MSB - SEL_LSB + 1;
  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

  state_t            state_reg, state_next;
  logic [SEL_W-1:0]  sel_reg, sel_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [31:0]       rdata_reg, rdata_next;
  logic [31:0]       err_addr_reg, err_addr_next;
  logic              err_irq_reg, err_irq_next;
  logic              err_timeout_reg, err_timeout_next;

  logic [FW-1:0]         field;
  logic [NUM_SLAVES-1:0] hit;
  logic [SEL_W-1:0]      hit_idx;
  logic                  hit_any;
  logic                  sel_ready;
  logic [31:0]           sel_rdata;

  // Address decode: one comparator per slot.
  assign field = iomem_addr[SEL_MSB:SEL_LSB];

  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_decode
      assign hit[gi]     = (field == SLOT_IDS[8*gi +: FW]);
      assign s_valid[gi] = (state_reg == ACTIVE) && (sel_reg == SEL_W'(gi));
    end
  endgenerate

  // Lowest matching index wins: scan downwards so the last assignment is the lowest hit.
  always_comb begin
    hit_idx = '0;
    hit_any = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_idx = SEL_W'(i);
        hit_any = 1'b1;
      end
    end
  end

  // Only the selected slot's ready/rdata are ever looked at.
  assign sel_ready = s_ready[sel_reg] | ALWAYS_READY[sel_reg];
  assign sel_rdata = s_rdata[32*sel_reg +: 32];

  always_comb begin
    state_next       = state_reg;
    sel_next         = sel_reg;
    count_next       = count_reg;
    rdata_next       = rdata_reg;
    err_addr_next    = err_addr_reg;
    err_timeout_next = err_timeout_reg;
    err_irq_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (iomem_valid) begin
          if (hit_any) begin
            sel_next   = hit_idx;
            count_next = '0;
            state_next = ACTIVE;
          end else begin
            rdata_next       = '0;
            err_irq_next     = 1'b1;
            err_addr_next    = iomem_addr;
            err_timeout_next = 1'b0;
            state_next       = RESP;
          end
        end
      end
      ACTIVE: begin
        count_next = (count_reg == CNT_MAX) ? count_reg : count_reg + 1'b1;
        // A slave that answers in the timeout cycle still wins over the abort.
        if (sel_ready) begin
          rdata_next = sel_rdata;
          state_next = RESP;
        end else if (count_reg == CNT_LAST) begin
          rdata_next       = '0;
          err_irq_next     = 1'b1;
          err_addr_next    = iomem_addr;
          err_timeout_next = 1'b1;
          state_next       = RESP;
        end else if (!iomem_valid) begin
          state_next = IDLE;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      sel_reg         <= '0;
      count_reg       <= '0;
      rdata_reg       <= '0;
      err_addr_reg    <= '0;
      err_irq_reg     <= 1'b0;
      err_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      sel_reg         <= sel_next;
      count_reg       <= count_next;
      rdata_reg       <= rdata_next;
      err_addr_reg    <= err_addr_next;
      err_irq_reg     <= err_irq_next;
      err_timeout_reg <= err_timeout_next;
    end
  end

  assign iomem_ready = (state_reg == RESP);
  assign iomem_rdata = rdata_reg;
  assign err_irq     = err_irq_reg;
  assign err_addr    = err_addr_reg;
  assign err_timeout = err_timeout_reg;

  assign s_wstrb = iomem_wstrb;
  assign s_addr  = iomem_addr;
  assign s_wdata = iomem_wdata;

endmodule

// File: tb/tb_iomem_fabric.sv
// Testbench for iomem_fabric: directed accesses, a transaction-level
// reference model compared every cycle, and literal spot checks.
module tb_iomem_fabric;
  localparam int N  = 4;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            iomem_valid;
  logic            iomem_ready;
  logic [3:0]      iomem_wstrb;
  logic [31:0]     iomem_addr;
  logic [31:0]     iomem_wdata;
  logic [31:0]     iomem_rdata;
  logic [N-1:0]    s_valid;
  logic [N-1:0]    s_ready;
  logic [32*N-1:0] s_rdata;
  logic [3:0]      s_wstrb;
  logic [31:0]     s_addr;
  logic [31:0]     s_wdata;
  logic            err_irq;
  logic [31:0]     err_addr;
  logic            err_timeout;

  iomem_fabric #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
    .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_rdata(s_rdata),
    .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata),
    .err_irq(err_irq), .err_addr(err_addr), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit armed    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] ids [N] = '{8'h03, 8'h04, 8'h05, 8'h07};
  bit         ar  [N] = '{1'b0, 1'b1, 1'b1, 1'b0};

  function automatic int lookup(input logic [31:0] a);
    for (int i = 0; i < N; i++) if (a[31:24] == ids[i]) return i;
    return -1;
  endfunction

  bit          m_busy = 0, m_resp = 0, m_irq = 0, m_eto = 0;
  int          m_slot = 0, m_age = 0;
  logic [31:0] m_rdata = 0, m_eaddr = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0; m_resp = 0; m_irq = 0; m_eto = 0; m_rdata = 0; m_eaddr = 0;
    end else begin
      m_irq = 0;
      if (m_resp) begin
        m_resp = 0;
      end else if (!m_busy) begin
        if (iomem_valid) begin
          int s;
          s = lookup(iomem_addr);
          if (s >= 0) begin
            m_busy = 1; m_slot = s; m_age = 0;
          end else begin
            m_resp = 1; m_rdata = 0; m_irq = 1; m_eaddr = iomem_addr; m_eto = 0;
          end
        end
      end else begin
        m_age++;  // number of cycles the request has been presented to the slave
        if (s_ready[m_slot] || ar[m_slot]) begin
          m_busy = 0; m_resp = 1; m_rdata = s_rdata[32*m_slot +: 32];
        end else if (m_age == TO) begin
          m_busy = 0; m_resp = 1; m_rdata = 0; m_irq = 1; m_eaddr = iomem_addr; m_eto = 1;
        end else if (!iomem_valid) begin
          m_busy = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("cmp iomem_ready", 32'(iomem_ready), 32'(m_resp));
      check("cmp s_valid", 32'(s_valid), m_busy ? (32'd1 << m_slot) : 32'd0);
      check("cmp err_irq", 32'(err_irq), 32'(m_irq));
      check("cmp err_addr", err_addr, m_eaddr);
      check("cmp err_timeout", 32'(err_timeout), 32'(m_eto));
      if (m_resp) check("cmp iomem_rdata", iomem_rdata, m_rdata);
      check("cmp s_addr", s_addr, iomem_addr);
      check("cmp s_wdata", s_wdata, iomem_wdata);
      check("cmp s_wstrb", 32'(s_wstrb), 32'(iomem_wstrb));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset = 1; iomem_valid = 0; iomem_wstrb = 0; iomem_addr = 0; iomem_wdata = 0;
    s_ready = 0;
    s_rdata = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h0000_00A5};
    step(); armed = 1; step();
    @(negedge clk);
    check("reset iomem_ready", 32'(iomem_ready), 0);
    check("reset s_valid", 32'(s_valid), 0);
    check("reset iomem_rdata", iomem_rdata, 0);
    check("reset err_addr", err_addr, 0);
    check("reset err_irq/timeout", {30'd0, err_irq, err_timeout}, 0);
    step(); reset = 0; step();

    // Read slot 0, slave ready in cycle 1
    iomem_valid = 1; iomem_addr = 32'h0300_0004; iomem_wstrb = 0;
    step(); s_ready = 4'b0001;
    @(negedge clk); check("t1 s_valid cycle1", 32'(s_valid), 32'h1);
    step(); s_ready = 0; iomem_valid = 0;
    @(negedge clk);
    check("t1 ready cycle2", 32'(iomem_ready), 1);
    check("t1 rdata", iomem_rdata, 32'h0000_00A5);
    step();

    // Write always-ready slot 1
    iomem_valid = 1; iomem_addr = 32'h0400_0000; iomem_wstrb = 4'hF; iomem_wdata = 32'hDEAD_BEEF;
    step();
    @(negedge clk); check("t2 s_valid cycle1", 32'(s_valid), 32'h2);
    step(); iomem_valid = 0; iomem_wstrb = 0;
    @(negedge clk);
    check("t2 ready cycle2", 32'(iomem_ready), 1);
    check("t2 no err_irq", 32'(err_irq), 0);
    step();
    @(negedge clk); check("t2 ready one cycle", 32'(iomem_ready), 0);
    step();

    // Decode miss
    iomem_valid = 1; iomem_addr = 32'h0900_0000;
    step(); iomem_valid = 0;
    @(negedge clk);
    check("t3 ready cycle1", 32'(iomem_ready), 1);
    check("t3 rdata", iomem_rdata, 0);
    check("t3 err_irq", 32'(err_irq), 1);
    check("t3 err_addr", err_addr, 32'h0900_0000);
    check("t3 err_timeout", 32'(err_timeout), 0);
    step();
    @(negedge clk); check("t3 err_irq cleared", 32'(err_irq), 0);
    step();

    // Slot 3 never ready (s_ready on unselected slot 0 must be ignored)
    iomem_valid = 1; iomem_addr = 32'h0700_0010; s_ready = 4'b0001;
    step();
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (iomem_ready) break;
      if (s_valid == 4'b1000) cnt++;
      step();
    end
    check("t4 active cycles", 32'(cnt), 8);
    check("t4 ready", 32'(iomem_ready), 1);
    check("t4 err_irq", 32'(err_irq), 1);
    check("t4 err_timeout", 32'(err_timeout), 1);
    check("t4 rdata", iomem_rdata, 0);
    check("t4 err_addr", err_addr, 32'h0700_0010);
    iomem_valid = 0; s_ready = 0;
    step(); step();

    // Slave ready exactly in the timeout cycle
    s_rdata[31:0] = 32'h1234_5678;
    iomem_valid = 1; iomem_addr = 32'h0300_0000;
    step();
    for (int k = 0; k < 7; k++) step();
    s_ready = 4'b0001;
    @(negedge clk); check("t5 s_valid last cycle", 32'(s_valid), 32'h1);
    step(); iomem_valid = 0; s_ready = 0;
    @(negedge clk);
    check("t5 ready", 32'(iomem_ready), 1);
    check("t5 rdata", iomem_rdata, 32'h1234_5678);
    check("t5 no err_irq", 32'(err_irq), 0);
    step();

    // Master abort
    iomem_valid = 1; iomem_addr = 32'h0700_0000;
    step(); iomem_valid = 0;
    step();
    @(negedge clk);
    check("t6 abort s_valid", 32'(s_valid), 0);
    check("t6 abort no ready", 32'(iomem_ready), 0);
    step();

    // Reset during ACTIVE, then a normal access
    iomem_valid = 1; iomem_addr = 32'h0700_0000;
    step(); reset = 1;
    step();
    @(negedge clk);
    check("t7 reset s_valid", 32'(s_valid), 0);
    check("t7 reset no ready", 32'(iomem_ready), 0);
    check("t7 reset err_timeout", 32'(err_timeout), 0);
    reset = 0; iomem_addr = 32'h0300_0000; s_rdata[31:0] = 32'h0000_0055; s_ready = 4'b0001;
    step();
    @(negedge clk); check("t7 after s_valid", 32'(s_valid), 32'h1);
    step(); iomem_valid = 0; s_ready = 0;
    @(negedge clk);
    check("t7 after ready", 32'(iomem_ready), 1);
    check("t7 after rdata", iomem_rdata, 32'h0000_0055);
    step();

    // Back-to-back accesses to always-ready slot 2
    iomem_valid = 1; iomem_addr = 32'h0500_0000;
    cnt = 0;
    for (int k = 0; k < 9; k++) begin
      step();
      @(negedge clk);
      if (iomem_ready) cnt++;
    end
    check("t8 back-to-back responses", 32'(cnt), 3);
    check("t8 rdata slot2", iomem_rdata, 32'h3333_3333);
    iomem_valid = 0;
    step(); step(); step();

    armed = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
